// File: rtl/fifo_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_reader_pkg
//   Shared constants and types for the capture-FIFO read engine.
//   - FRD_B0_LOADED / FRD_B0_EMPTY_READ : bit positions of the status flags
//     carried in byte 0 of every word served to the USB read mux.
//   - frd_state_t : drain engine states (IDLE, FETCH, LOADED).
//   - FRD_LAST_IDX : byte index of the final byte of a word.
// ---------------------------------------------------------------------------
package fifo_reader_pkg;

  localparam int FRD_B0_LOADED     = 7;
  localparam int FRD_B0_EMPTY_READ = 6;

  localparam logic [1:0] FRD_LAST_IDX = 2'd2;

  typedef enum logic [1:0] {
    FRD_IDLE   = 2'd0,
    FRD_FETCH  = 2'd1,
    FRD_LOADED = 2'd2
  } frd_state_t;

endpackage

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//   Read-side drain engine for the shared capture FIFO (cwusb_clk domain).
//   Prefetches one 18-bit FIFO entry into a holding register and serves it
//   to the USB register interface as three byte reads.
//
//   Optional feature: define FIFO_READER_STATS_EN to build the words-read
//   counter; without it O_words_read is tied to zero.
//
//   Ports:
//     cwusb_clk      in   sole clock
//     reset_n        in   async assert, active-low reset
//     I_fifo_data    in   FIFO dout, valid the cycle after O_fifo_read
//     I_fifo_empty   in   FIFO empty flag
//     O_fifo_read    out  FIFO read enable, single-cycle pulse
//     I_byte_rd      in   strobe: host consumes the current O_byte
//     O_byte         out  byte presented to the USB read mux
//     I_flush        in   level: discard held word, suppress fetches
//     I_clear_flags  in   clears O_empty_read
//     O_empty_read   out  sticky: byte read while no word was held
//     O_word_loaded  out  holding register valid
//     O_words_read   out  words fully consumed (0 without the stats build)
// ---------------------------------------------------------------------------
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int pDATA_WIDTH  = 18,
  parameter int pSTATS_WIDTH = 32
) (
  input  logic                    cwusb_clk,
  input  logic                    reset_n,
  input  logic [pDATA_WIDTH-1:0]  I_fifo_data,
  input  logic                    I_fifo_empty,
  output logic                    O_fifo_read,
  input  logic                    I_byte_rd,
  output logic [7:0]              O_byte,
  input  logic                    I_flush,
  input  logic                    I_clear_flags,
  output logic                    O_empty_read,
  output logic                    O_word_loaded,
  output logic [pSTATS_WIDTH-1:0] O_words_read
);

  frd_state_t             state, state_next;
  logic [1:0]             idx, idx_next;
  logic [pDATA_WIDTH-1:0] hold;
  logic                   hold_capture;
  logic                   empty_read_set;

  // State, byte index, holding register and sticky empty-read flag.
  // The empty-read set takes priority over a clear in the same cycle so a
  // host never misses an underflow that coincides with its clear.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FRD_IDLE;
      idx          <= 2'd0;
      hold         <= '0;
      O_empty_read <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (hold_capture) begin
        hold <= I_fifo_data;
      end
      if (empty_read_set) begin
        O_empty_read <= 1'b1;
      end else if (I_clear_flags) begin
        O_empty_read <= 1'b0;
      end
    end
  end

  // Next-state logic. The read enable is gated by reset_n so it is held low
  // for the whole time reset is asserted, not just after the first edge.
  // Flush beats a byte strobe: the word is dropped and not counted.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    hold_capture   = 1'b0;
    O_fifo_read    = 1'b0;
    empty_read_set = I_byte_rd && (state != FRD_LOADED);
    case (state)
      FRD_IDLE: begin
        if (reset_n && !I_fifo_empty && !I_flush) begin
          O_fifo_read = 1'b1;
          state_next  = FRD_FETCH;
        end
      end
      FRD_FETCH: begin
        if (I_flush) begin
          state_next = FRD_IDLE;
        end else begin
          hold_capture = 1'b1;
          state_next   = FRD_LOADED;
        end
      end
      FRD_LOADED: begin
        if (I_flush) begin
          state_next = FRD_IDLE;
        end else if (I_byte_rd) begin
          if (idx == FRD_LAST_IDX) begin
            idx_next   = 2'd0;
            state_next = FRD_IDLE;
          end else begin
            idx_next = idx + 2'd1;
          end
        end
      end
      default: begin
        state_next = FRD_IDLE;
      end
    endcase
    if (I_flush) begin
      idx_next = 2'd0;
    end
  end

  // Byte presented to the read mux. Byte 0 carries the loaded and
  // empty-read flags alongside the top two data bits; when nothing is held
  // only the empty-read flag is visible.
  always_comb begin
    O_byte                    = 8'h00;
    O_byte[FRD_B0_EMPTY_READ] = O_empty_read;
    if (state == FRD_LOADED) begin
      case (idx)
        2'd0: begin
          O_byte[FRD_B0_LOADED] = 1'b1;
          O_byte[1:0]           = hold[17:16];
        end
        2'd1:    O_byte = hold[15:8];
        2'd2:    O_byte = hold[7:0];
        default: O_byte = 8'h00;
      endcase
    end
  end

  assign O_word_loaded = (state == FRD_LOADED);

`ifdef FIFO_READER_STATS_EN
  logic                    word_done;
  logic [pSTATS_WIDTH-1:0] words_cnt;

  assign word_done = (state == FRD_LOADED) && I_byte_rd && !I_flush &&
                     (idx == FRD_LAST_IDX);

  // Words fully consumed by the host; wraps naturally at its width.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      words_cnt <= '0;
    end else if (word_done) begin
      words_cnt <= words_cnt + 1'b1;
    end
  end

  assign O_words_read = words_cnt;
`else
  assign O_words_read = {pSTATS_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_reader
//   Bench for fifo_reader. A queue-based FIFO model feeds the DUT; a
//   word-level reference model predicts each byte the host sees, and a
//   negedge monitor compares every strobed byte against the predictions.
// ---------------------------------------------------------------------------
module tb_fifo_reader;

  logic        cwusb_clk = 1'b0;
  logic        reset_n;
  logic [17:0] I_fifo_data;
  logic        I_fifo_empty;
  logic        O_fifo_read;
  logic        I_byte_rd;
  logic [7:0]  O_byte;
  logic        I_flush;
  logic        I_clear_flags;
  logic        O_empty_read;
  logic        O_word_loaded;
  logic [31:0] O_words_read;

  int total = 0;
  int bad   = 0;

  logic [17:0] fifoQ[$];
  logic [17:0] modelQ[$];
  logic [7:0]  expQ[$];
  int          modelPos   = 0;
  bit          modelEr    = 1'b0;
  int          modelWords = 0;
  int          pulseCount = 0;
  bit          prevRd     = 1'b0;

  fifo_reader dut (
    .cwusb_clk     (cwusb_clk),
    .reset_n       (reset_n),
    .I_fifo_data   (I_fifo_data),
    .I_fifo_empty  (I_fifo_empty),
    .O_fifo_read   (O_fifo_read),
    .I_byte_rd     (I_byte_rd),
    .O_byte        (O_byte),
    .I_flush       (I_flush),
    .I_clear_flags (I_clear_flags),
    .O_empty_read  (O_empty_read),
    .O_word_loaded (O_word_loaded),
    .O_words_read  (O_words_read)
  );

  always #5 cwusb_clk = ~cwusb_clk;

  // Scoreboard monitor: compares the byte on every host strobe, and checks
  // that read enables are single pulses, never on empty, never in flush.
  always @(negedge cwusb_clk) begin
    logic [7:0] e;
    if (I_byte_rd === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL byte_unexpected: got 0x%02h required no strobe", O_byte);
      end else begin
        e = expQ.pop_front();
        if (O_byte !== e) begin
          bad++;
          $display("[TB] FAIL byte_value: got 0x%02h required 0x%02h", O_byte, e);
        end
      end
    end
    if (O_fifo_read === 1'b1) begin
      pulseCount++;
      total++;
      if (I_fifo_empty || prevRd || I_flush) begin
        bad++;
        $display("[TB] FAIL fifo_read_rule: empty=%0b prev=%0b flush=%0b required all 0",
                 I_fifo_empty, prevRd, I_flush);
      end
    end
    prevRd = O_fifo_read;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] expWords();
`ifdef FIFO_READER_STATS_EN
    return 32'(modelWords);
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, required);
    end
  endtask

  // One clock: the FIFO model pops on a sampled read enable and presents
  // the word shortly after the edge, so it is valid for the following edge.
  task automatic tick();
    bit rd;
    @(negedge cwusb_clk);
    rd = O_fifo_read;
    @(posedge cwusb_clk);
    #1;
    if (rd && fifoQ.size() > 0) begin
      I_fifo_data = fifoQ.pop_front();
    end
    I_fifo_empty = (fifoQ.size() == 0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic rd, input logic clr);
    I_byte_rd     = rd;
    I_clear_flags = clr;
    tick();
    I_byte_rd     = 1'b0;
    I_clear_flags = 1'b0;
  endtask

  task automatic pushWord(input logic [17:0] w, input bit toModel);
    fifoQ.push_back(w);
    I_fifo_empty = 1'b0;
    if (toModel) modelQ.push_back(w);
  endtask

  // Word-level reference: a held word yields its three bytes in order;
  // with nothing held the host sees only the empty-read flag, which then
  // becomes set. A flush with the strobe drops the word uncounted.
  task automatic strobe(input bit withFlush, input bit withClr, input int gap);
    logic [17:0] w;
    logic [7:0]  e;
    if (modelQ.size() > 0) begin
      w = modelQ[0];
      if (modelPos == 0)      e = {1'b1, modelEr, 4'b0000, w[17:16]};
      else if (modelPos == 1) e = w[15:8];
      else                    e = w[7:0];
      if (withFlush) begin
        void'(modelQ.pop_front());
        modelPos = 0;
      end else if (modelPos == 2) begin
        void'(modelQ.pop_front());
        modelPos = 0;
        modelWords++;
      end else begin
        modelPos++;
      end
      if (withClr) modelEr = 1'b0;
    end else begin
      e = {1'b0, modelEr, 6'b000000};
      modelEr = 1'b1;
    end
    expQ.push_back(e);
    if (withFlush) I_flush = 1'b1;
    applyStimulus(1'b1, withClr);
    I_flush = 1'b0;
    waitCycles(gap - 1);
  endtask

  task automatic clearFlags();
    modelEr = 1'b0;
    applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    int base;
    int r;
    reset_n       = 1'b1;
    I_fifo_data   = '0;
    I_fifo_empty  = 1'b1;
    I_byte_rd     = 1'b0;
    I_flush       = 1'b0;
    I_clear_flags = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_byte", O_byte, 8'h00);
    checkOutput("rst_fifo_read", O_fifo_read, 0);
    checkOutput("rst_loaded", O_word_loaded, 0);
    checkOutput("rst_empty_read", O_empty_read, 0);
    checkOutput("rst_words", O_words_read, 0);
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(2);

    $display("[TB] single word 0x2A5C3");
    base = pulseCount;
    pushWord(18'h2A5C3, 1);
    waitCycles(5);
    checkOutput("t1_loaded", O_word_loaded, 1);
    repeat (3) strobe(0, 0, 6);
    checkOutput("t1_words", O_words_read, expWords());
    checkOutput("t1_pulses", pulseCount - base, 1);
    checkOutput("t1_unloaded", O_word_loaded, 0);

    $display("[TB] empty read with simultaneous clear");
    strobe(0, 1, 5);
    checkOutput("t2_er_set", O_empty_read, 1);
    pushWord(18'h12345, 1);
    waitCycles(4);
    repeat (3) strobe(0, 0, 4);
    clearFlags();
    checkOutput("t2_er_clr", O_empty_read, 0);

    $display("[TB] back-to-back words");
    pushWord(18'h00001, 1);
    pushWord(18'h3FFFF, 1);
    waitCycles(4);
    strobe(0, 0, 4);
    strobe(0, 0, 4);
    strobe(0, 0, 1);
    checkOutput("t3_n1_loaded", O_word_loaded, 0);
    checkOutput("t3_n1_read", O_fifo_read, 1);
    waitCycles(1);
    checkOutput("t3_n2_loaded", O_word_loaded, 0);
    waitCycles(1);
    checkOutput("t3_n3_loaded", O_word_loaded, 1);
    waitCycles(1);
    repeat (3) strobe(0, 0, 4);

    $display("[TB] flush during fetch");
    pushWord(18'h15555, 0);
    tick();
    I_flush = 1'b1;
    checkOutput("t4_fetch_loaded", O_word_loaded, 0);
    tick();
    pushWord(18'h0ABCD, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_flush_loaded", O_word_loaded, 0);
      checkOutput("t4_flush_read", O_fifo_read, 0);
      tick();
    end
    I_flush = 1'b0;
    waitCycles(4);
    repeat (3) strobe(0, 0, 4);

    $display("[TB] async reset mid-word");
    pushWord(18'h2F0F0, 1);
    pushWord(18'h1C3A5, 1);
    waitCycles(4);
    strobe(0, 0, 2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5_byte", O_byte, 8'h00);
    checkOutput("t5_loaded", O_word_loaded, 0);
    checkOutput("t5_fifo_read", O_fifo_read, 0);
    checkOutput("t5_words", O_words_read, 0);
    void'(modelQ.pop_front());
    modelPos   = 0;
    modelEr    = 1'b0;
    modelWords = 0;
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(4);
    repeat (3) strobe(0, 0, 4);

    $display("[TB] flush with final byte strobe");
    pushWord(18'h3A1B2, 1);
    waitCycles(4);
    strobe(0, 0, 4);
    strobe(0, 0, 4);
    strobe(1, 0, 4);
    checkOutput("t6_words", O_words_read, expWords());
    checkOutput("t6_loaded", O_word_loaded, 0);
    pushWord(18'h0F00F, 1);
    waitCycles(4);
    repeat (3) strobe(0, 0, 4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (modelQ.size() == 0 && r < 2) begin
        strobe(0, 0, 4);
      end else if (r < 4) begin
        repeat ($urandom_range(1, 2)) pushWord(18'($urandom), 1);
        waitCycles(4);
      end else if (r == 4) begin
        clearFlags();
        waitCycles(3);
      end else if (modelQ.size() > 0) begin
        strobe(0, 0, $urandom_range(4, 8));
      end
    end
    while (modelQ.size() > 0) strobe(0, 0, 4);
    checkOutput("rand_words", O_words_read, expWords());
    checkOutput("rand_er", O_empty_read, 32'(modelEr));
    checkOutput("rand_loaded", O_word_loaded, 0);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
